jt900h_prefetch: RTL

- Parametrised op-code prefetch queue feeding the instruction controller.
- Fetches from the program bus in aligned beats of BUSW bits and stores the bytes in a circular byte queue of DEPTH entries.
- Presents a 4-byte little-endian op window (op[7:0] = next byte) with op_ok, and retires 0..3 bytes per cycle via the controller's fetched count.
- Handles jumps with flush/flush_pc: arbitrary byte alignment, and discards an in-flight read.

---
 rtl/jt900h_prefetch_pkg.sv | 20 ++
 rtl/jt900h_prefetch_ram.sv | 46 ++++
 rtl/jt900h_prefetch.sv | 130 +++++++++++++
 3 files changed

// File: rtl/jt900h_prefetch_pkg.sv
// Shared types and constants for the JT900H op-code prefetch queue.
package jt900h_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  localparam int MAX_FETCH = 3;

  function automatic int busw_bytes(input int busw);
    return busw / 8;
  endfunction

  function automatic int skip_width(input int busw);
    return $clog2(busw / 8);
  endfunction

endpackage

// File: rtl/jt900h_prefetch_ram.sv
// Circular byte store: multi-lane write at the write pointer, 4-byte window read at the read pointer.
module jt900h_prefetch_ram
  import jt900h_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter int  LANES = 2,
  localparam int PW    = $clog2(DEPTH)
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cen,
  input  logic               i_we,
  input  logic [PW-1:0]      i_wr_ptr,
  input  logic [LANES-1:0]   i_lane_mask,
  input  logic [8*LANES-1:0] i_wdata,
  input  logic [PW-1:0]      i_rd_ptr,
  output logic [31:0]        o_window
);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] w_lane_addr [LANES];
  logic [PW-1:0] w_rd_addr [4];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_addr[gi] = i_wr_ptr + PW'(gi);
    end
    // Window bytes wrap around the end of the store independently.
    for (gi = 0; gi < 4; gi++) begin : g_rd
      assign w_rd_addr[gi]       = i_rd_ptr + PW'(gi);
      assign o_window[8*gi +: 8] = r_mem[w_rd_addr[gi]];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (i_cen && i_we) begin
      for (int j = 0; j < LANES; j++) begin
        if (i_lane_mask[j]) r_mem[w_lane_addr[j]] <= i_wdata[8*j +: 8];
      end
    end
  end

endmodule

// File: rtl/jt900h_prefetch.sv
// Op-code prefetch queue: fetches aligned bus beats into a byte FIFO and presents a 4-byte op window.
module jt900h_prefetch
  import jt900h_pkg::*;
#(
  parameter int              DEPTH  = 8,
  parameter int              BUSW   = 16,
  parameter int              AW     = 24,
  parameter logic [AW-1:0]   RST_PC = '0
)(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cen,
  input  logic                               flush,
  input  logic [AW-1:0]                      flush_pc,
  input  logic [$clog2(MAX_FETCH+1)-1:0]     fetched,
  output logic [31:0]                        op,
  output logic                               op_ok,
  output logic [AW-1:0]                      pc,
  output logic                               bus_rd,
  output logic [AW-1:0]                      bus_addr,
  input  logic [BUSW-1:0]                    bus_din,
  input  logic                               bus_ok
);

  localparam int BB  = busw_bytes(BUSW);
  localparam int SKW = skip_width(BUSW);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  fetch_state_e  r_state, w_state_next;
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_pc, r_bus_addr;
  logic [SKW-1:0] r_skip;
  logic          r_op_ok;

  logic          w_take, w_consume;
  logic [CW-1:0] w_wr_n, w_fetch_n, w_cnt_next, w_free, w_free_next;
  logic [BB-1:0] w_lane_mask;
  logic [BUSW-1:0] w_wdata;

  // Flush wins over both the incoming beat and the consume.
  assign w_take      = cen && (r_state == FETCH_REQ) && bus_ok && !flush;
  assign w_consume   = cen && r_op_ok && (fetched != '0) && !flush;
  assign w_wr_n      = CW'(BB) - CW'(r_skip);
  assign w_fetch_n   = w_consume ? CW'(fetched) : '0;
  assign w_cnt_next  = flush ? '0 : r_cnt + (w_take ? w_wr_n : '0) - w_fetch_n;
  assign w_free      = CW'(DEPTH) - r_cnt;
  assign w_free_next = CW'(DEPTH) - w_cnt_next;
  assign w_wdata     = bus_din >> {r_skip, 3'b000};
  assign w_lane_mask = {BB{1'b1}} >> r_skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= FETCH_IDLE;
    else if (cen) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      FETCH_IDLE: if (!flush && w_free >= CW'(BB)) w_state_next = FETCH_REQ;
      FETCH_REQ: begin
        if (flush)       w_state_next = bus_ok ? FETCH_IDLE : FETCH_DROP;
        else if (bus_ok) w_state_next = (w_free_next >= CW'(BB)) ? FETCH_REQ : FETCH_IDLE;
      end
      FETCH_DROP: if (bus_ok) w_state_next = FETCH_IDLE;
      default: w_state_next = FETCH_IDLE;
    endcase
  end

  always_comb begin
    bus_rd = (r_state != FETCH_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_op_ok    <= 1'b0;
      r_pc       <= RST_PC;
      r_bus_addr <= RST_PC & ~AW'(BB - 1);
      r_skip     <= RST_PC[SKW-1:0];
    end else if (cen) begin
      r_cnt   <= w_cnt_next;
      r_op_ok <= (w_cnt_next >= CW'(4));
      if (flush) begin
        r_rd_ptr   <= r_wr_ptr;
        r_pc       <= flush_pc;
        r_bus_addr <= flush_pc & ~AW'(BB - 1);
        r_skip     <= flush_pc[SKW-1:0];
      end else begin
        if (w_consume) begin
          r_rd_ptr <= r_rd_ptr + PW'(fetched);
          r_pc     <= r_pc + AW'(fetched);
        end
        if (w_take) begin
          r_wr_ptr   <= r_wr_ptr + w_wr_n[PW-1:0];
          r_bus_addr <= r_bus_addr + AW'(BB);
          r_skip     <= '0;
        end
      end
    end
  end

  jt900h_prefetch_ram #(
    .DEPTH (DEPTH),
    .LANES (BB)
  ) u_ram (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cen       (cen),
    .i_we        (w_take),
    .i_wr_ptr    (r_wr_ptr),
    .i_lane_mask (w_lane_mask),
    .i_wdata     (w_wdata),
    .i_rd_ptr    (r_rd_ptr),
    .o_window    (op)
  );

  assign op_ok    = r_op_ok;
  assign pc       = r_pc;
  assign bus_addr = r_bus_addr;

  // Consuming from a short queue is a controller bug; the request is ignored.
  a_fetch_ok: assert property (@(posedge clk) disable iff (!rst_n)
                               (cen && !flush && fetched != '0) |-> op_ok)
    else $warning("jt900h_prefetch: fetched=%0d while op_ok=0 ignored", fetched);

endmodule
